// File: rtl/mult_div_pkg.sv
// Shared types and sizing for the multicycle signed multiply/divide unit.
package mult_div_pkg;
  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = 32;
  localparam int MD_CNT_W = 6;

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} md_state_t;
endpackage

// File: rtl/mult_div_div_core.sv
// Restoring divider datapath on operand magnitudes, with sign fix-up on the outputs.
// Compiled only when MULT_DIV_DIV_EN is defined.
`ifdef MULT_DIV_DIV_EN
module div_core
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);
  logic [WIDTH-1:0] r, qd, d, a_mag, b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             neg_q, neg_r;

  // |-2^(W-1)| still fits as an unsigned W-bit magnitude
  always_comb begin
    a_mag   = a[WIDTH-1] ? -a : a;
    b_mag   = b[WIDTH-1] ? -b : b;
    shifted = {r, qd[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r     <= '0;
      qd    <= '0;
      d     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (load) begin
      r     <= '0;
      qd    <= a_mag;
      d     <= b_mag;
      neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r <= a[WIDTH-1];
    end else if (step) begin
      if (!diff[WIDTH+1]) begin
        r  <= diff[WIDTH-1:0];
        qd <= {qd[WIDTH-2:0], 1'b1};
      end else begin
        r  <= shifted[WIDTH-1:0];
        qd <= {qd[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Remainder follows the dividend sign: truncation toward zero
  assign quot = neg_q ? -qd : qd;
  assign rem  = neg_r ? -r  : r;
endmodule
`endif

// File: rtl/mult_div.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit writing HI/LO.
// Divider is present only when MULT_DIV_DIV_EN is defined; otherwise every divide reports div_zero.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  md_state_t           state, state_n;
  logic [MD_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]    m, q, res_hi, res_lo;
  logic [WIDTH:0]      acc, booth_sum;
  logic                qm1, dz, last;
  logic                ld_mult, set_dz, fin;

  assign last = (cnt == MD_CNT_W'(MD_ITER - 1));

  // acc carries one guard bit so acc -= M cannot overflow when M = -2^(W-1)
  always_comb begin
    case ({q[0], qm1})
      2'b01:   booth_sum = acc + {m[WIDTH-1], m};
      2'b10:   booth_sum = acc - {m[WIDTH-1], m};
      default: booth_sum = acc;
    endcase
  end

`ifdef MULT_DIV_DIV_EN
  logic             div_load, div_step, op_div;
  logic [WIDTH-1:0] div_quot, div_rem;

  div_core #(.WIDTH(WIDTH)) u_div (
    .clk   (clk),
    .reset (reset),
    .load  (div_load),
    .step  (div_step),
    .a     (a),
    .b     (b),
    .quot  (div_quot),
    .rem   (div_rem)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         op_div <= 1'b0;
    else if (ld_mult)  op_div <= 1'b0;
    else if (div_load) op_div <= 1'b1;
  end

  assign res_hi = op_div ? div_rem  : acc[WIDTH-1:0];
  assign res_lo = op_div ? div_quot : q;
`else
  assign res_hi = acc[WIDTH-1:0];
  assign res_lo = q;
`endif

  always_comb begin
    state_n = state;
    ld_mult = 1'b0;
    set_dz  = 1'b0;
    fin     = 1'b0;
`ifdef MULT_DIV_DIV_EN
    div_load = 1'b0;
    div_step = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (mult_start) begin
          state_n = MULT;
          ld_mult = 1'b1;
        end else if (div_start) begin
`ifdef MULT_DIV_DIV_EN
          if (b == '0) begin
            state_n = FINISH;
            set_dz  = 1'b1;
          end else begin
            state_n  = DIV;
            div_load = 1'b1;
          end
`else
          state_n = FINISH;
          set_dz  = 1'b1;
`endif
        end
      end
      MULT: if (last) state_n = FINISH;
      DIV: begin
`ifdef MULT_DIV_DIV_EN
        div_step = 1'b1;
`endif
        if (last) state_n = FINISH;
      end
      FINISH: begin
        fin     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      m        <= '0;
      q        <= '0;
      acc      <= '0;
      qm1      <= 1'b0;
      dz       <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_n;
      busy     <= (state_n != IDLE);
      done     <= fin;
      div_zero <= fin & dz;

      if (state == IDLE)                       cnt <= '0;
      else if (state == MULT || state == DIV)  cnt <= cnt + MD_CNT_W'(1);

      if (state == IDLE) dz <= set_dz;

      // Arithmetic shift of {acc, Q, q-1} right by one after the add/sub
      if (ld_mult) begin
        m   <= a;
        q   <= b;
        acc <= '0;
        qm1 <= 1'b0;
      end else if (state == MULT) begin
        acc <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        q   <= {booth_sum[0], q[WIDTH-1:1]};
        qm1 <= q[0];
      end

      if (fin && !dz) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end
endmodule

// File: tb/tb_mult_div.sv
// Scoreboard bench for mult_div: random and directed multiply/divide against a longint model.
module tb_mult_div;
  logic        clk = 1'b0, reset = 1'b1, mult_start = 1'b0, div_start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          start;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0, errors = 0, cyc = 0, n_done = 0, n_exp = 0;
  logic [31:0] mhi = '0, mlo = '0;

  mult_div dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, expv, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (!reset) begin
      if (div_zero && !done) chk("dz_without_done", div_zero, 1'b0);
      if (done) begin
        n_done++;
        if (sb.size() == 0) chk("unexpected_done", done, 1'b0);
        else begin
          mon_e = sb.pop_front();
          chk("hi", hi, mon_e.hi);
          chk("lo", lo, mon_e.lo);
          chk("div_zero", div_zero, mon_e.dz);
          chk("latency", cyc - mon_e.start, mon_e.lat);
        end
      end
    end
  end

  // Caller must be at a negedge; start is sampled at the following posedge.
  // poke>0 pulses div_start (with junk operands) so it is sampled at edge E<poke> while busy.
  task automatic do_op(input bit mul, input bit dv, input logic [31:0] av, input logic [31:0] bv,
                       input int poke);
    exp_t   e;
    longint p, qa, qb, qq, rr;
    int     n;
    bit     busy_bad;
    a = av; b = bv; mult_start = mul; div_start = dv;
    e.start = cyc + 1; e.dz = 1'b0; e.lat = 33;
    if (mul) begin
      p   = longint'($signed(av)) * longint'($signed(bv));
      mhi = p[63:32];
      mlo = p[31:0];
    end else begin
`ifdef MULT_DIV_DIV_EN
      if (bv != 0) begin
        qa  = longint'($signed(av));
        qb  = longint'($signed(bv));
        qq  = qa / qb;
        rr  = qa % qb;
        mhi = rr[31:0];
        mlo = qq[31:0];
      end else begin
        e.dz = 1'b1; e.lat = 1;
      end
`else
      e.dz = 1'b1; e.lat = 1;
`endif
    end
    e.hi = mhi; e.lo = mlo;
    sb.push_back(e);
    n_exp++;
    @(negedge clk);
    mult_start = 1'b0; div_start = 1'b0;
    n = 0; busy_bad = 0;
    while (!done && n < 60) begin
      if (!busy) busy_bad = 1;
      if (poke > 0 && n == poke - 1) begin
        div_start = 1'b1; a = 32'h1234_5678; b = 32'h0;
      end else div_start = 1'b0;
      @(negedge clk);
      n++;
    end
    div_start = 1'b0;
    chk("done_seen", done, 1'b1);
    chk("busy_during_op", busy_bad, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int          k;
    logic [31:0] av, bv;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dz", div_zero, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    do_op(1, 0, 32'hFFFF_FFFD, 32'd7, 0);
    do_op(1, 0, 32'h8000_0000, 32'h8000_0000, 0);
    do_op(1, 0, 32'd1, 32'd2, 0);
    do_op(0, 1, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(0, 1, 32'd5, 32'd0, 0);
    do_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(1, 1, 32'd6, 32'hFFFF_FFFB, 0);
    do_op(1, 0, 32'd123, 32'd456, 10);

    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 3);
      av = $urandom;
      bv = (k == 0) ? 32'h0 : (k == 1) ? ($urandom_range(1, 9) * (($urandom_range(0, 1) == 1) ? -1 : 1))
                                       : $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op($urandom_range(0, 1) == 1, 1'b1, av, bv, 0);
    end

    // Abandon a multiply with an asynchronous reset mid-operation
    do_op(1, 0, 32'hFFFF_FFFD, 32'd7, 0);
    a = 32'd7; b = 32'd9; mult_start = 1'b1;
    @(negedge clk);
    mult_start = 1'b0;
    repeat (14) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    mhi = '0; mlo = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_done_after_reset", n_done, n_exp);
    do_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    repeat (5) @(negedge clk);
    chk("done_count", n_done, n_exp);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
